// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver, oversampled on a shared sample-enable tick.
// Latency: i_RX -> rx_s 2 i_CLK; byte delivered on the stop-sample tick (T0 + OVERSAMPLE/2 + 9*OVERSAMPLE ticks).
// Backpressure: none on the line; an unread byte is overwritten by the next one and o_OVERRUN is set.
//
// Ports:
//   i_CLK, i_RESET     : clock and synchronous active-high reset
//   i_SAMPLE_EN        : one-cycle oversample tick at baud * OVERSAMPLE
//   i_RX               : asynchronous serial line, idle high
//   i_READ             : consumer acknowledge, effective while o_DATA_VALID=1
//   o_DATA             : last received byte (held after read)
//   o_DATA_VALID       : o_DATA holds an unread byte
//   o_FRAME_ERR        : stop bit of the byte in o_DATA was sampled low
//   o_OVERRUN          : sticky, a byte completed while the previous one was unread
//   o_RX_BUSY          : receiver FSM is mid-frame
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_SAMPLE_EN,
  input  logic       i_RX,
  input  logic       i_READ,
  output logic [7:0] o_DATA,
  output logic       o_DATA_VALID,
  output logic       o_FRAME_ERR,
  output logic       o_OVERRUN,
  output logic       o_RX_BUSY
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            complete;
  logic            rd_ack;

  // Receive FSM; only advances on sample ticks so a stalled tick freezes the frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_meta_d = i_RX;
    rx_s_d    = rx_meta_q;
    complete  = 1'b0;

    if (i_SAMPLE_EN) begin
      case (state_q)
        s_IDLE: begin
          if (!rx_s_q) begin
            state_d = s_START;
            cnt_d   = '0;
          end
        end
        s_START: begin
          if (cnt_q != HALF_M1) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!rx_s_q) begin
            // Mid start bit still low: counter now re-centred on bit midpoints.
            state_d   = s_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = s_IDLE;
          end
        end
        s_DATA: begin
          if (cnt_q == FULL_M1) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            cnt_d   = '0;
            // bit_idx holds at 7 rather than wrapping; STOP resets nothing it needs.
            if (bit_idx_q == 3'd7) begin
              state_d = s_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        s_STOP: begin
          if (cnt_q == FULL_M1) begin
            complete = 1'b1;
            state_d  = s_IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = s_IDLE;
      endcase
    end
  end

  // Consumer handshake runs every cycle; a completing byte wins over a read clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    rd_ack  = i_READ & valid_q;

    if (complete) begin
      data_d  = shift_q;
      ferr_d  = !rx_s_q;
      valid_d = 1'b1;
      if (valid_q && !i_READ) begin
        ovr_d = 1'b1;
      end else if (rd_ack) begin
        ovr_d = 1'b0;
      end
    end else if (rd_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= s_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_DATA       = data_q;
  assign o_DATA_VALID = valid_q;
  assign o_FRAME_ERR  = ferr_q;
  assign o_OVERRUN    = ovr_q;
  assign o_RX_BUSY    = (state_q != s_IDLE);

endmodule
